ce_output_buf_axil: RTL
=======================

CE_OUTPUT_BUF_AXIL -- requirements
Module: ce_output_buf_axil

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6: AXI4-Lite byte address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: capture FIFO depth in words; power of 2, range 4..256.
REQ-004 SHALL have parameter NUM_SCRATCH, default 4: number of R/W scratch registers, range 1..8.
REQ-005 SHALL have port S_AXI_ACLK, input, 1 bit: the only clock.
REQ-006 SHALL have port S_AXI_ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports S_AXI_AWADDR/AWPROT/AWVALID (inputs) and AWREADY (output): write address channel; AWPROT is ignored.
REQ-008 SHALL have ports S_AXI_WDATA/WSTRB/WVALID (inputs) and WREADY (output): write data channel.
REQ-009 SHALL have outputs S_AXI_BRESP/BVALID and input S_AXI_BREADY: write response channel.
REQ-010 SHALL have ports S_AXI_ARADDR/ARPROT/ARVALID (inputs) and ARREADY (output): read address channel.
REQ-011 SHALL have outputs S_AXI_RDATA/RRESP/RVALID and input S_AXI_RREADY: read data channel.
REQ-012 SHALL have ports in_tdata (input, 32 bits), in_tvalid (input, 1 bit) and in_tready (output, 1 bit): the CE result stream.

Function
REQ-013 SHALL implement this word map: 0x00 CTRL (bit0 enable, bit1 flush, bit2 clear_sticky); 0x04 STATUS (RO); 0x08 DATA (RO, pops on read); 0x0C THRESH; 0x10+4*i SCRATCH[i].
REQ-014 STATUS bits SHALL be: [0] empty, [1] full, [2] overflow sticky, [3] underflow sticky, [4] irq_pending, [16+:9] count.
REQ-015 SHALL accept a write only when AWVALID and WVALID are both high and BVALID is low; AWREADY and WREADY pulse high together for exactly 1 cycle; BVALID rises the next cycle and holds until BREADY.
REQ-016 SHALL accept a read when ARVALID is high and RVALID is low; ARREADY pulses for 1 cycle; RVALID and RDATA appear the next cycle and hold until RREADY.
REQ-017 BRESP and RRESP SHALL always be OKAY (2'b00); unmapped reads SHALL return 0 and unmapped writes SHALL be ignored.
REQ-018 Writes to CTRL, THRESH and SCRATCH SHALL honour WSTRB per byte; writes to STATUS and DATA SHALL be ignored.
REQ-019 CTRL bits flush and clear_sticky SHALL self-clear: each acts for 1 cycle and always reads back 0.
REQ-020 in_tready SHALL equal enable; a word SHALL be pushed when in_tvalid, in_tready and not full are all high.
REQ-021 A word offered with in_tvalid and in_tready high while full SHALL be dropped and SHALL set the overflow sticky bit.
REQ-022 When AR is accepted to DATA and the FIFO is not empty, the head word SHALL be latched into RDATA and popped in that cycle.
REQ-023 A read of DATA while empty SHALL return 0 and SHALL set the underflow sticky bit.
REQ-024 A simultaneous push and pop SHALL leave count unchanged; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Flush SHALL zero count and both pointers in 1 cycle; a push in the same cycle SHALL be discarded; the sticky bits SHALL NOT be affected.
REQ-026 clear_sticky SHALL zero overflow and underflow; if an event occurs in the same cycle, the set SHALL win.

Reset
REQ-027 Asserting S_AXI_ARESETN low SHALL asynchronously clear AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, CTRL, THRESH, SCRATCH, pointers, count, sticky bits and irq.
REQ-028 Reset mid-transaction SHALL abandon it; no BVALID or RVALID SHALL appear after release until a new request arrives; FIFO contents SHALL be discarded.

Configuration
REQ-029 With CE_OBUF_IRQ_EN defined, output irq (1 bit) SHALL exist and be registered high while enable and THRESH != 0 and count >= THRESH[8:0]; STATUS[4] SHALL mirror irq.
REQ-030 Without CE_OBUF_IRQ_EN, irq SHALL be absent, STATUS[4] SHALL read 0, and THRESH SHALL remain a plain R/W register.

Verification
REQ-031 Write 0x0101FFFF, 0xABCD0001, 0xDEADBEEF and 0xBEEF0011 to SCRATCH0..3 and read each back -> data matches, every response OKAY.
REQ-032 With CTRL=1, push 16 words 0..15 and then a 17th -> STATUS = full, overflow, count 16; 16 DATA reads return 0..15; the next read returns 0 with underflow set.
REQ-033 With 8 words held, issue a continuous push and a DATA read in the same cycle -> count stays 8; the read returns the oldest word.
REQ-034 Write WSTRB=4'b0010 with WDATA=0x0000AB00 to SCRATCH1 holding 0x11223344 -> it reads 0x1122AB44.
REQ-035 With 5 words held, write CTRL=0x3 -> count 0 and empty; then write CTRL=0x5 -> sticky bits clear and CTRL reads 0x1.
REQ-036 With CE_OBUF_IRQ_EN, THRESH=4: push 3 words -> irq 0; push a 4th -> irq 1 one cycle later; one DATA read -> irq 0; an ARESETN pulse mid-read -> no RVALID, all status 0.

Source files
------------

// File: rtl/ce_output_buf_axil.sv
// rtl/ce_output_buf_axil.sv - AXI4-Lite slave buffering the CE result stream in a capture FIFO
// Optional interrupt output enabled by defining CE_OBUF_IRQ_EN.
module ce_output_buf_axil #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH         = 16,
  parameter int NUM_SCRATCH        = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [31:0]                       in_tdata,
  input  logic                              in_tvalid,
  output logic                              in_tready
`ifdef CE_OBUF_IRQ_EN
  ,
  output logic                              irq
`endif
);

  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [IW-1:0] widx, ridx;
  logic          wr_accept, wr_en, rd_accept, rd_en;
  logic          ctrl_wr, flush, clr_sticky;
  logic          enable;
  logic [31:0]   thresh;
  logic [31:0]   scratch [NUM_SCRATCH];
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [8:0]    count;
  logic          fifo_empty, fifo_full;
  logic          push, pop, ovf_evt, unf_evt;
  logic          ovf, unf, irq_q;
  logic [31:0]   status, rd_mux;
  logic          unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign widx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ridx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Ready is registered, so the accept term masks itself to keep it a single-cycle pulse.
  assign wr_accept = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~S_AXI_AWREADY;
  assign wr_en     = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_accept = S_AXI_ARVALID & ~S_AXI_RVALID & ~S_AXI_ARREADY;
  assign rd_en     = S_AXI_ARREADY & S_AXI_ARVALID;

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  assign ctrl_wr    = wr_en && (widx == IW'(0));
  assign flush      = ctrl_wr & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
  assign clr_sticky = ctrl_wr & S_AXI_WSTRB[0] & S_AXI_WDATA[2];

  assign in_tready  = enable;
  assign fifo_empty = (count == 9'd0);
  assign fifo_full  = (count == 9'(FIFO_DEPTH));
  assign push       = in_tvalid & enable & ~fifo_full & ~flush;
  assign ovf_evt    = in_tvalid & enable & fifo_full;
  assign pop        = rd_en && (ridx == IW'(2)) && !fifo_empty;
  assign unf_evt    = rd_en && (ridx == IW'(2)) && fifo_empty;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_AWREADY <= wr_accept;
      S_AXI_WREADY  <= wr_accept;
      S_AXI_ARREADY <= rd_accept;
      if (wr_en)
        S_AXI_BVALID <= 1'b1;
      else if (S_AXI_BREADY)
        S_AXI_BVALID <= 1'b0;
      if (rd_en) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      enable <= 1'b0;
      thresh <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else if (wr_en) begin
      if (widx == IW'(0) && S_AXI_WSTRB[0]) enable <= S_AXI_WDATA[0];
      if (widx == IW'(3)) thresh <= apply_strb(thresh, S_AXI_WDATA, S_AXI_WSTRB);
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (widx == IW'(4 + i)) scratch[i] <= apply_strb(scratch[i], S_AXI_WDATA, S_AXI_WSTRB);
    end
  end

  // Storage is not reset; pointers and count alone define what is valid.
  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem[wptr] <= in_tdata;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        count <= count + {8'd0, push} - {8'd0, pop};
      end
      // A same-cycle event beats clear_sticky.
      if (ovf_evt)         ovf <= 1'b1;
      else if (clr_sticky) ovf <= 1'b0;
      if (unf_evt)         unf <= 1'b1;
      else if (clr_sticky) unf <= 1'b0;
    end
  end

`ifdef CE_OBUF_IRQ_EN
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)
      irq_q <= 1'b0;
    else
      irq_q <= enable && (thresh != 32'd0) && (count >= thresh[8:0]);
  end
  assign irq = irq_q;
`else
  assign irq_q = 1'b0;
`endif

  assign status = {7'd0, count, 11'd0, irq_q, unf, ovf, fifo_full, fifo_empty};

  always_comb begin
    rd_mux = '0;
    case (ridx)
      IW'(0):  rd_mux = {31'd0, enable};
      IW'(1):  rd_mux = status;
      IW'(2):  rd_mux = fifo_empty ? 32'd0 : mem[rptr];
      IW'(3):  rd_mux = thresh;
      default: rd_mux = '0;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (ridx == IW'(4 + i)) rd_mux = scratch[i];
  end

endmodule
